// File: rtl/npu_pkg.sv
// Shared NPU input-path types and constants. Element width comes from `DATA_WIDTH
// (defaults to 8 when the build does not supply it).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package npu_pkg;

  localparam int ELEM_W   = `DATA_WIDTH;
  localparam int IN_N_DEF = 16;
  localparam int IDX_W    = $clog2(IN_N_DEF);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_t;

  // Index width for an n-slot vector; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_buffer.sv
// One IN_N x DW register bank: single-slot writes, whole-bank clear, and zeroing of
// every slot above the written index when a vector is closed early.
module vec_buffer
  import npu_pkg::*;
#(
  parameter int IN_N = 16,
  parameter int DW   = ELEM_W,
  parameter int IW   = idx_width(IN_N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               we_i,
  input  logic               zfill_i,
  input  logic [IW-1:0]      idx_i,
  input  logic [DW-1:0]      data_i,
  output logic [IN_N*DW-1:0] vec_o
);

  logic [IN_N*DW-1:0] vec_q;
  logic [IN_N*DW-1:0] vec_d;

  // Per-slot next value: clear wins, then the write, then zero-fill above the index
  always_comb begin
    vec_d = vec_q;
    for (int k = 0; k < IN_N; k++) begin
      if (clr_i) begin
        vec_d[k*DW +: DW] = '0;
      end else if (we_i && (int'(idx_i) == k)) begin
        vec_d[k*DW +: DW] = data_i;
      end else if (zfill_i && (k > int'(idx_i))) begin
        vec_d[k*DW +: DW] = '0;
      end else begin
        vec_d[k*DW +: DW] = vec_q[k*DW +: DW];
      end
    end
  end

  // Bank storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
    end else begin
      vec_q <= vec_d;
    end
  end

  assign vec_o = vec_q;

endmodule

// File: rtl/vec_loader.sv
// Packs a stream of signed elements into IN_N-element vectors behind a valid/ready pair.
// Define DOUBLE_BUF_EN for ping/pong banks so filling overlaps presentation (no bubble).
module vec_loader
  import npu_pkg::*;
#(
  parameter int IN_N       = 16,
  parameter int DATA_WIDTH = ELEM_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic                       s_valid,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic [IN_N*DATA_WIDTH-1:0] m_vec,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       err_frame
);

  localparam int            IW       = idx_width(IN_N);
  localparam int            VW       = IN_N * DATA_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(IN_N - 1);
`ifdef DOUBLE_BUF_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  loader_state_t   state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [VW-1:0]   m_vec_q, m_vec_d;
  logic            m_valid_q, m_valid_d;
  logic            err_q, err_d;
  logic [NBUF-1:0] full_q, full_d;
  logic [NBUF-1:0] we_s, clr_s, zf_s;
  logic [VW-1:0]   bank_vec_s [NBUF];
  logic            s_ready_s, accept_s, at_end_s, complete_s, hs_s, wr_full_nxt_s;

  // The closing element is not in the bank yet, so the presented vector is built from
  // the bank contents with that element inserted and every higher slot forced to zero.
  function automatic logic [VW-1:0] merge_last(input logic [VW-1:0]         bank,
                                               input logic [IW-1:0]         at,
                                               input logic [DATA_WIDTH-1:0] d);
    logic [VW-1:0] r;
    r = bank;
    for (int k = 0; k < IN_N; k++) begin
      if (k == int'(at)) begin
        r[k*DATA_WIDTH +: DATA_WIDTH] = d;
      end else if (k > int'(at)) begin
        r[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else begin
        r[k*DATA_WIDTH +: DATA_WIDTH] = bank[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return r;
  endfunction

  assign accept_s   = s_valid && s_ready_s;
  assign at_end_s   = (idx_q == LAST_IDX);
  assign complete_s = accept_s && (s_last || at_end_s);
  assign hs_s       = m_valid_q && m_ready;

  for (genvar b = 0; b < NBUF; b++) begin : g_buf
    vec_buffer #(
      .IN_N (IN_N),
      .DW   (DATA_WIDTH),
      .IW   (IW)
    ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (clr_s[b]),
      .we_i    (we_s[b]),
      .zfill_i (zf_s[b]),
      .idx_i   (idx_q),
      .data_i  (s_data),
      .vec_o   (bank_vec_s[b])
    );
  end

`ifdef DOUBLE_BUF_EN
  logic wr_sel_q, wr_sel_d;
  logic rd_sel_q, rd_sel_d;

  // Ping/pong bookkeeping: fill bank wr_sel, present bank rd_sel, queue the other
  always_comb begin
    full_d    = full_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    m_vec_d   = m_vec_q;
    m_valid_d = m_valid_q;
    we_s      = '0;
    zf_s      = '0;
    clr_s     = '0;
    we_s[wr_sel_q]  = accept_s;
    zf_s[wr_sel_q]  = complete_s;
    clr_s[rd_sel_q] = hs_s;
    if (hs_s) begin
      full_d[rd_sel_q] = 1'b0;
    end else begin
      full_d[rd_sel_q] = full_q[rd_sel_q];
    end
    if (complete_s) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end else begin
      wr_sel_d = wr_sel_q;
    end
    if (complete_s && (!m_valid_q || hs_s)) begin
      m_vec_d   = merge_last(bank_vec_s[wr_sel_q], idx_q, s_data);
      m_valid_d = 1'b1;
      rd_sel_d  = wr_sel_q;
    end else if (hs_s && full_q[~rd_sel_q]) begin
      m_vec_d   = bank_vec_s[~rd_sel_q];
      m_valid_d = 1'b1;
      rd_sel_d  = ~rd_sel_q;
    end else if (hs_s) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
    wr_full_nxt_s = full_d[wr_sel_d];
  end

  // Bank selectors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end
`else
  // Single bank: present on completion, clear the bank on the consumer handshake
  always_comb begin
    we_s  = accept_s;
    zf_s  = complete_s;
    clr_s = hs_s;
    if (complete_s) begin
      full_d    = 1'b1;
      m_vec_d   = merge_last(bank_vec_s[0], idx_q, s_data);
      m_valid_d = 1'b1;
    end else if (hs_s) begin
      full_d    = 1'b0;
      m_vec_d   = m_vec_q;
      m_valid_d = 1'b0;
    end else begin
      full_d    = full_q;
      m_vec_d   = m_vec_q;
      m_valid_d = m_valid_q;
    end
    wr_full_nxt_s = full_d[0];
  end
`endif

  // Write index and framing-error detection
  always_comb begin
    if (complete_s) begin
      idx_d = '0;
    end else if (accept_s) begin
      idx_d = idx_q + IW'(1);
    end else begin
      idx_d = idx_q;
    end
    err_d = accept_s && (s_last != at_end_s);
  end

  // FSM next state: HOLD once no bank is free to fill
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    state_d = (complete_s && wr_full_nxt_s) ? HOLD : FILL;
      HOLD:    state_d = hs_s ? FILL : HOLD;
      default: state_d = FILL;
    endcase
  end

  // FSM outputs
  always_comb begin
    s_ready_s = 1'b0;
    case (state_q)
      FILL:    s_ready_s = 1'b1;
      HOLD:    s_ready_s = 1'b0;
      default: s_ready_s = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      m_vec_q   <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
      full_q    <= '0;
    end else begin
      idx_q     <= idx_d;
      m_vec_q   <= m_vec_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
      full_q    <= full_d;
    end
  end

  assign s_ready   = s_ready_s;
  assign m_vec     = m_vec_q;
  assign m_valid   = m_valid_q;
  assign err_frame = err_q;

endmodule

// File: tb/tb_vec_loader.sv
// Scoreboard bench for vec_loader (IN_N=4): a frame model fed by observed input handshakes
// predicts vectors and framing errors; a monitor checks every presented vector.
module tb_vec_loader;
  import npu_pkg::*;

  localparam int IN_N = 4;
  localparam int DW   = ELEM_W;
  localparam int VW   = IN_N * DW;
`ifdef DOUBLE_BUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif
  localparam int PERIOD = DBL ? IN_N : IN_N + 1;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [VW-1:0] m_vec;
  logic          m_valid;
  logic          m_ready;
  logic          err_frame;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int mr_mode = 0;          // 0: always ready, 1: random, 2: stalled
  logic [DW-1:0] cur_q[$];  // elements of the frame being collected
  logic [VW-1:0] exp_q[$];  // vectors expected on the output, in order
  int            hs_cyc[$]; // cycle stamps of output handshakes

  vec_loader #(.IN_N(IN_N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_vec     (m_vec),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .err_frame (err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [VW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [VW-1:0] v;
    v = '0;
    v[0*DW +: DW] = DW'(a);
    v[1*DW +: DW] = DW'(b);
    v[2*DW +: DW] = DW'(c);
    v[3*DW +: DW] = DW'(d);
    return v;
  endfunction

  // Consumer ready pattern
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor + reference model: frames close on s_last or after IN_N elements
  initial begin : mon
    logic [VW-1:0] v;
    logic          err_pend;
    err_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        err_pend = 1'b0;
      end else begin
        check("err_frame", VW'(err_frame), VW'(err_pend));
        err_pend = 1'b0;
        if (m_valid) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_vector: got %h with empty scoreboard", m_vec);
          end else begin
            check("m_vec", m_vec, exp_q[0]);
            if (m_ready) begin
              void'(exp_q.pop_front());
              hs_cyc.push_back(cyc);
            end
          end
        end
        if (s_valid && s_ready) begin
          cur_q.push_back(s_data);
          if (s_last || cur_q.size() == IN_N) begin
            v = '0;
            foreach (cur_q[i]) v[i*DW +: DW] = cur_q[i];
            err_pend = (s_last != (cur_q.size() == IN_N));
            exp_q.push_back(v);
            cur_q.delete();
          end
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic last, input int gap);
    bit ok;
    s_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    ok = 1'b0;
    for (int g = 0; g < 300 && !ok; g++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: s_ready low for 300 cycles, element %h", d);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    mr_mode = 0;
    while ((exp_q.size() != 0 || m_valid) && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain", VW'(exp_q.size() == 0 && !m_valid), VW'(1));
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_m_valid", VW'(m_valid), VW'(0));
    check("rst_m_vec", m_vec, '0);
    check("rst_s_ready", VW'(s_ready), VW'(1));
    check("rst_err", VW'(err_frame), VW'(0));
    @(posedge clk);
    #1;

    // Full frame with s_last on the final element
    send(DW'(1), 1'b0, 0);
    send(DW'(2), 1'b0, 0);
    send(DW'(3), 1'b0, 0);
    send(DW'(-4), 1'b1, 0);
    @(negedge clk);
    check("t1_valid", VW'(m_valid), VW'(1));
    check("t1_vec", m_vec, pack4(1, 2, 3, -4));
    check("t1_err", VW'(err_frame), VW'(0));
    drain();

    // Early s_last zero-fills; the following frame starts at slot 0
    send(DW'(5), 1'b0, 0);
    send(DW'(6), 1'b1, 0);
    @(negedge clk);
    check("t2_vec", m_vec, pack4(5, 6, 0, 0));
    check("t2_err", VW'(err_frame), VW'(1));
    @(negedge clk);
    check("t2_err_pulse", VW'(err_frame), VW'(0));
    @(posedge clk);
    #1;
    send(DW'(7), 1'b0, 0);
    send(DW'(8), 1'b0, 0);
    send(DW'(9), 1'b0, 0);
    send(DW'(10), 1'b1, 0);
    @(negedge clk);
    check("t2_next_vec", m_vec, pack4(7, 8, 9, 10));
    drain();

    // Consumer stalled: vector held, input back-pressured once storage is full
    mr_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < IN_N; i++) send(DW'(11 + i), (i == IN_N - 1), 0);
    @(negedge clk);
    check("t3_valid", VW'(m_valid), VW'(1));
    check("t3_s_ready_after_one", VW'(s_ready), VW'(DBL));
    @(posedge clk);
    #1;
`ifdef DOUBLE_BUF_EN
    for (int i = 0; i < IN_N; i++) send(DW'(21 + i), (i == IN_N - 1), 0);
`endif
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_s_ready_full", VW'(s_ready), VW'(0));
      check("t3_hold_valid", VW'(m_valid), VW'(1));
      check("t3_hold_vec", m_vec, pack4(11, 12, 13, 14));
    end
    @(posedge clk);
    #1;
    drain();

    // Reset mid-fill discards the partial vector
    send(DW'(31), 1'b0, 0);
    send(DW'(32), 1'b0, 0);
    rst_n = 1'b0;
    cur_q.delete();
    exp_q.delete();
    @(negedge clk);
    check("t4_valid", VW'(m_valid), VW'(0));
    check("t4_vec", m_vec, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(DW'(41), 1'b0, 0);
    send(DW'(42), 1'b0, 0);
    send(DW'(43), 1'b0, 0);
    send(DW'(44), 1'b1, 0);
    @(negedge clk);
    check("t4_clean_vec", m_vec, pack4(41, 42, 43, 44));
    drain();

    // Back-to-back throughput: 100 vectors
    hs_cyc.delete();
    for (int i = 0; i < 100 * IN_N; i++) send(DW'($urandom), ((i % IN_N) == IN_N - 1), 0);
    drain();
    check("t5_count", VW'(hs_cyc.size()), VW'(100));
    if (hs_cyc.size() == 100) check("t5_span", VW'(hs_cyc[99] - hs_cyc[0]), VW'(99 * PERIOD));

    // Random stalls on both sides, random framing
    mr_mode = 1;
    for (int i = 0; i < 200; i++) begin
      send(DW'($urandom), ($urandom_range(0, 9) == 0), $urandom_range(0, 2));
    end
    if (cur_q.size() != 0) send(DW'($urandom), 1'b1, 0);
    drain();
    check("t6_model_empty", VW'(cur_q.size()), VW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
